ahb_modport: RTL and testbench

- AHB-lite slave with an internal word-organised memory.
- Accepts single and burst transfers from an AHB-lite master or interconnect.
- Returns zero-wait-state OKAY responses for legal transfers and a two-cycle ERROR response for illegal ones.
- Sits behind the address decoder (hsel) and drives hreadyout/hresp back to the multiplexor.

---
 rtl/ahb_modport.sv | 136 +++++++++++++
 tb/tb_ahb_modport.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/ahb_modport.sv
// AHB-lite slave with a byte-lane organised word memory.
// Zero-wait OKAY for legal transfers, two-cycle ERROR for out-of-range,
// oversized or misaligned transfers. Memory is cleared by reset.

// One byte lane of the word memory; all lanes share the registered word index.
module ahb_modport_lane #(
  parameter int DEPTH = 256,
  parameter int IW    = 8
) (
  input  logic          hclk,
  input  logic          hresetn,
  input  logic          we,
  input  logic [IW-1:0] idx,
  input  logic [7:0]    din,
  output logic [7:0]    dout
);
  logic [7:0] mem [DEPTH];

  // Byte storage: cleared on reset, written when this lane is enabled.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= 8'h00;
    end else if (we) begin
      mem[idx] <= din;
    end
  end

  assign dout = mem[idx];
endmodule

module ahb_modport #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MEM_DEPTH  = 256
) (
  input  logic                  hclk,
  input  logic                  hresetn,
  input  logic                  hsel,
  input  logic [ADDR_WIDTH-1:0] haddr,
  input  logic [1:0]            htrans,
  input  logic                  hwrite,
  input  logic [2:0]            hsize,
  input  logic [2:0]            hburst,
  input  logic [3:0]            hprot,
  input  logic                  hready,
  input  logic [DATA_WIDTH-1:0] hwdata,
  output logic                  hreadyout,
  output logic [DATA_WIDTH-1:0] hrdata,
  output logic                  hresp
);
  localparam int NUM_LANES = DATA_WIDTH / 8;
  localparam int IW        = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_DATA = 2'd1;
  localparam logic [1:0] ST_ERR1 = 2'd2;
  localparam logic [1:0] ST_ERR2 = 2'd3;

  logic [1:0]            state;
  logic [IW-1:0]         idx_q;
  logic [1:0]            off_q;
  logic [2:0]            size_q;
  logic                  wr_q;
  logic                  accept, legal, in_range, aligned;
  logic [NUM_LANES-1:0]  be;
  logic [DATA_WIDTH-1:0] rword;

  // hburst/hprot are informational; bursts are handled beat by beat.
  logic unused_ok;
  assign unused_ok = ^{hburst, hprot, htrans[0]};

  // ERR1 holds hreadyout low, so nothing can be accepted during it.
  assign accept   = hsel && hready && htrans[1] && (state != ST_ERR1);
  assign in_range = haddr < ADDR_WIDTH'(MEM_DEPTH * 4);

  // Alignment: halfword needs addr[0]=0, word needs addr[1:0]=0.
  always_comb begin
    aligned = 1'b1;
    case (hsize)
      3'b001:  aligned = ~haddr[0];
      3'b010:  aligned = (haddr[1:0] == 2'b00);
      default: aligned = 1'b1;
    endcase
  end

  assign legal = in_range && (hsize <= 3'b010) && aligned;

  // Response FSM plus address-phase capture.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state  <= ST_IDLE;
      idx_q  <= '0;
      off_q  <= '0;
      size_q <= '0;
      wr_q   <= 1'b0;
    end else if (state == ST_ERR1) begin
      state <= ST_ERR2;
    end else if (accept) begin
      state  <= legal ? ST_DATA : ST_ERR1;
      idx_q  <= haddr[IW+1:2];
      off_q  <= haddr[1:0];
      size_q <= hsize;
      wr_q   <= hwrite;
    end else begin
      state <= ST_IDLE;
    end
  end

  // Little-endian byte enables for the registered size/offset.
  always_comb begin
    be = '0;
    case (size_q)
      3'b000:  be = 4'b0001 << off_q;
      3'b001:  be = off_q[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
  end

  genvar g;
  generate
    for (g = 0; g < NUM_LANES; g++) begin : g_lane
      ahb_modport_lane #(.DEPTH(MEM_DEPTH), .IW(IW)) u_lane (
        .hclk    (hclk),
        .hresetn (hresetn),
        .we      ((state == ST_DATA) && wr_q && be[g]),
        .idx     (idx_q),
        .din     (hwdata[8*g +: 8]),
        .dout    (rword[8*g +: 8])
      );
    end
  endgenerate

  assign hrdata    = ((state == ST_DATA) && !wr_q) ? rword : '0;
  assign hreadyout = (state != ST_ERR1);
  assign hresp     = (state == ST_ERR1) || (state == ST_ERR2);
endmodule

// File: tb/tb_ahb_modport.sv
// Randomized + directed bench for ahb_modport against a byte-array model.
module tb_ahb_modport;
  localparam int DEPTH = 256;
  localparam int NB    = DEPTH * 4;

  logic        hclk = 1'b0;
  logic        hresetn;
  logic        hsel, hwrite, hready;
  logic [31:0] haddr, hwdata, hrdata;
  logic [1:0]  htrans;
  logic [2:0]  hsize, hburst;
  logic [3:0]  hprot;
  logic        hreadyout, hresp;

  ahb_modport #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(DEPTH)) dut (
    .hclk(hclk), .hresetn(hresetn), .hsel(hsel), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hprot(hprot), .hready(hready),
    .hwdata(hwdata), .hreadyout(hreadyout), .hrdata(hrdata), .hresp(hresp)
  );

  always #5 hclk = ~hclk;

  int ntests = 0;
  int nfail  = 0;

  // Reference model: byte-addressed memory plus the pending data phase.
  localparam int K_NONE = 0, K_RD = 1, K_WR = 2, K_E1 = 3, K_E2 = 4;
  logic [7:0]  mem_m [NB];
  int          cur;
  int unsigned cur_addr, cur_size;
  logic        obs_rdy, obs_resp;
  logic [31:0] obs_data;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    ntests++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] word_at(input int unsigned a);
    int unsigned b = a & ~32'd3;
    return {mem_m[b+3], mem_m[b+2], mem_m[b+1], mem_m[b]};
  endfunction

  function automatic bit is_legal(input int unsigned a, input int unsigned sz);
    if (a >= NB) return 0;
    if (sz > 2) return 0;
    return (a % (1 << sz)) == 0;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < NB; i++) mem_m[i] = 8'h00;
    cur = K_NONE;
  endtask

  // Applies the edge that ends the current cycle to the model.
  task automatic model_edge();
    if (cur == K_WR)
      for (int b = 0; b < (1 << cur_size); b++)
        mem_m[cur_addr + b] = hwdata[8*((cur_addr + b) % 4) +: 8];
    if (cur == K_E1) cur = K_E2;
    else if (hsel && hready && htrans[1]) begin
      if (is_legal(haddr, hsize)) begin
        cur      = hwrite ? K_WR : K_RD;
        cur_addr = haddr;
        cur_size = hsize;
      end else cur = K_E1;
    end else cur = K_NONE;
  endtask

  // One bus cycle: drive address phase + current hwdata, check mid-cycle, advance.
  task automatic step(input logic sel, input logic [1:0] tr, input logic wr,
                      input logic [2:0] sz, input logic [31:0] a,
                      input logic [31:0] wd, input bit rdy_ok = 1);
    logic [31:0] e_data;
    hsel = sel; htrans = tr; hwrite = wr; hsize = sz; haddr = a; hwdata = wd;
    hready = (cur != K_E1) && rdy_ok;
    hburst = 3'($urandom); hprot = 4'($urandom);
    @(negedge hclk);
    e_data   = (cur == K_RD) ? word_at(cur_addr) : 32'h0;
    obs_rdy  = hreadyout; obs_resp = hresp; obs_data = hrdata;
    chk("hreadyout", {31'h0, hreadyout}, {31'h0, cur != K_E1});
    chk("hresp", {31'h0, hresp}, {31'h0, (cur == K_E1) || (cur == K_E2)});
    chk("hrdata", hrdata, e_data);
    @(posedge hclk);
    model_edge();
    #1;
  endtask

  initial begin
    hresetn = 1'b0; hsel = 0; htrans = 0; hwrite = 0; hsize = 0; haddr = 0;
    hwdata = 0; hready = 1; hburst = 0; hprot = 0;
    model_clear();
    repeat (2) @(posedge hclk);
    #1;
    chk("rst_rdy", {31'h0, hreadyout}, 32'h1);
    chk("rst_resp", {31'h0, hresp}, 32'h0);
    chk("rst_data", hrdata, 32'h0);
    @(negedge hclk) hresetn = 1'b1;
    @(posedge hclk); #1;

    // Reset during a write data phase: write abandoned, outputs idle at once.
    step(1, 2'b10, 1, 3'd2, 32'h30, 32'h0);
    hwdata = 32'h12345678; hsel = 0; htrans = 2'b00;
    #2 hresetn = 1'b0;
    #1;
    chk("rstmid_rdy", {31'h0, hreadyout}, 32'h1);
    chk("rstmid_resp", {31'h0, hresp}, 32'h0);
    chk("rstmid_data", hrdata, 32'h0);
    model_clear();
    @(negedge hclk) hresetn = 1'b1;
    @(posedge hclk); #1;
    step(1, 2'b10, 0, 3'd2, 32'h30, 32'h0);
    step(0, 2'b00, 0, 3'd0, 32'h0, 32'h0);
    chk("rstmid_word", obs_data, 32'h0);

    // Single word write then read.
    step(1, 2'b10, 1, 3'd2, 32'h10, 32'h0);
    step(1, 2'b10, 0, 3'd2, 32'h10, 32'hDEADBEEF);
    step(0, 2'b00, 0, 3'd0, 32'h0, 32'h0);
    chk("word_rd", obs_data, 32'hDEADBEEF);

    // Byte and halfword merges.
    step(1, 2'b10, 1, 3'd2, 32'h20, 32'h0);
    step(1, 2'b10, 1, 3'd0, 32'h21, 32'h11223344);
    step(1, 2'b10, 1, 3'd1, 32'h22, 32'h0000AA00);
    step(1, 2'b10, 0, 3'd2, 32'h20, 32'hBEEF0000);
    step(0, 2'b00, 0, 3'd0, 32'h0, 32'h0);
    chk("byte_half", obs_data, 32'hBEEFAA44);

    // INCR4 write, overlapping read, INCR4 read.
    step(1, 2'b10, 1, 3'd2, 32'h40, 32'h0);
    step(1, 2'b11, 1, 3'd2, 32'h44, 32'd1);
    step(1, 2'b11, 1, 3'd2, 32'h48, 32'd2);
    step(1, 2'b11, 1, 3'd2, 32'h4C, 32'd3);
    step(1, 2'b10, 0, 3'd2, 32'h4C, 32'd4);
    step(1, 2'b10, 0, 3'd2, 32'h40, 32'h0);
    chk("overlap_rd", obs_data, 32'd4);
    step(1, 2'b11, 0, 3'd2, 32'h44, 32'h0);
    chk("burst_rd1", obs_data, 32'd1);
    step(1, 2'b11, 0, 3'd2, 32'h48, 32'h0);
    chk("burst_rd2", obs_data, 32'd2);
    step(1, 2'b11, 0, 3'd2, 32'h4C, 32'h0);
    chk("burst_rd3", obs_data, 32'd3);
    step(0, 2'b00, 0, 3'd0, 32'h0, 32'h0);
    chk("burst_rd4", obs_data, 32'd4);

    // Out-of-range write, then misaligned word read.
    step(1, 2'b10, 1, 3'd2, NB, 32'h0);
    step(1, 2'b10, 1, 3'd2, NB, 32'hFFFFFFFF);
    chk("err1_rdy", {31'h0, obs_rdy}, 32'h0);
    chk("err1_resp", {31'h0, obs_resp}, 32'h1);
    step(0, 2'b00, 0, 3'd0, 32'h0, 32'hFFFFFFFF);
    chk("err2_rdy", {31'h0, obs_rdy}, 32'h1);
    chk("err2_resp", {31'h0, obs_resp}, 32'h1);
    step(1, 2'b10, 0, 3'd2, 32'h2, 32'h0);
    chk("idle_after_err", {31'h0, obs_resp}, 32'h0);
    step(1, 2'b10, 0, 3'd2, 32'h2, 32'h0);
    step(1, 2'b10, 0, 3'd2, 32'h0, 32'h0);
    chk("rderr2_resp", {31'h0, obs_resp}, 32'h1);
    step(1, 2'b10, 0, 3'd2, 32'h10, 32'h0);
    chk("post_err_resp", {31'h0, obs_resp}, 32'h0);
    chk("word0_intact", obs_data, 32'h0);
    step(0, 2'b00, 0, 3'd0, 32'h0, 32'h0);
    chk("post_err_data", obs_data, 32'hDEADBEEF);

    // IDLE/BUSY/deselected transfers never write.
    step(1, 2'b00, 1, 3'd2, 32'h10, 32'h0);
    step(1, 2'b01, 1, 3'd2, 32'h10, 32'h55555555);
    step(0, 2'b10, 1, 3'd2, 32'h10, 32'h66666666);
    step(1, 2'b10, 0, 3'd2, 32'h10, 32'h77777777);
    step(0, 2'b00, 0, 3'd0, 32'h0, 32'h0);
    chk("idle_nowrite", obs_data, 32'hDEADBEEF);

    // Random traffic, mostly in a small window so reads hit earlier writes.
    for (int n = 0; n < 600; n++) begin
      logic        s, w;
      logic [1:0]  t;
      logic [2:0]  z;
      logic [31:0] a;
      int unsigned r;
      s = ($urandom % 8) != 0;
      t = 2'($urandom);
      w = 1'($urandom);
      r = $urandom % 16;
      z = (r == 0) ? 3'(3 + $urandom % 5) : 3'($urandom % 3);
      r = $urandom % 16;
      if (r == 0) a = NB + ($urandom % 64);
      else begin
        a = $urandom % 128;
        if (r > 2 && z <= 2) a = a & ~((32'd1 << z) - 1);
      end
      step(s, t, w, z, a, $urandom, ($urandom % 8) != 0);
    end
    step(0, 2'b00, 0, 3'd0, 32'h0, 32'h0);

    // Final sweep of the window against the model.
    for (int i = 0; i < 128; i += 4) begin
      step(1, 2'b10, 0, 3'd2, i, 32'h0);
      step(0, 2'b00, 0, 3'd0, 32'h0, 32'h0);
    end

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
